// File: rtl/updown_tick_counter.sv
// Purpose : prescaled up/down step counter driven by two raw push-buttons, with load and boundary flags.
// Latency : buttons reach the step logic 2 clk later; a step, tick and wrap register 1 clk after the tick condition.
// Backpressure: none; en freezes the prescaler, and a press seen while frozen (edge mode) is held until the next tick.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   btn_up    raw asynchronous button, count up
//   btn_down  raw asynchronous button, count down
//   en        prescaler enable
//   load      synchronous load strobe, highest priority
//   load_val  value to load (clamped to MAX_VAL)
//   count     current count, registered
//   tick      one-cycle step strobe, registered
//   wrap      one-cycle pulse when the count wraps, registered
//   at_max    count == MAX_VAL, combinational
//   at_min    count == 0, combinational

module updown_tick_counter #(
   parameter int WIDTH     = 4,
   parameter int TICK_DIV  = 125000000,
   parameter int MAX_VAL   = (1 << WIDTH) - 1,
   parameter int SATURATE  = 0,
   parameter int EDGE_MODE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             wrap,
   output logic             at_max,
   output logic             at_min
);

   localparam int              PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [WIDTH-1:0] MAXV    = WIDTH'(MAX_VAL);

   // ---------------------------------------------------------------
   // Button synchronisers (2 flops) plus one extra stage for edges
   // ---------------------------------------------------------------
   logic btn_up_m, btn_up_s, btn_up_q;
   logic btn_down_m, btn_down_s, btn_down_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_up_m   <= 1'b0;
         btn_up_s   <= 1'b0;
         btn_up_q   <= 1'b0;
         btn_down_m <= 1'b0;
         btn_down_s <= 1'b0;
         btn_down_q <= 1'b0;
      end else begin
         btn_up_m   <= btn_up;
         btn_up_s   <= btn_up_m;
         btn_up_q   <= btn_up_s;
         btn_down_m <= btn_down;
         btn_down_s <= btn_down_m;
         btn_down_q <= btn_down_s;
      end
   end

   logic rise_up, rise_down;
   assign rise_up   = btn_up_s & ~btn_up_q;
   assign rise_down = btn_down_s & ~btn_down_q;

   // ---------------------------------------------------------------
   // Prescaler: 0..TICK_DIV-1, frozen (not cleared) while en=0
   // ---------------------------------------------------------------
   logic [PW-1:0] pre;
   logic          tick_fire;

   assign tick_fire = en && (pre == PRE_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre <= '0;
      end else if (en) begin
         if (tick_fire) begin
            pre <= '0;
         end else begin
            pre <= pre + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------
   // Pending press flags (edge mode). A rise arriving in the same
   // cycle as the clearing tick/load survives into the next window.
   // ---------------------------------------------------------------
   logic pend_up, pend_down;
   logic pend_clr;
   logic pend_up_d, pend_down_d;

   assign pend_clr    = tick_fire | load;
   assign pend_up_d   = (pend_up & ~pend_clr) | rise_up;
   assign pend_down_d = (pend_down & ~pend_clr) | rise_down;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_up   <= 1'b0;
         pend_down <= 1'b0;
      end else begin
         pend_up   <= pend_up_d;
         pend_down <= pend_down_d;
      end
   end

   // ---------------------------------------------------------------
   // Step decision
   // ---------------------------------------------------------------
   logic             up_req, down_req;
   logic [WIDTH-1:0] count_d;
   logic             wrap_d;

   assign up_req   = (EDGE_MODE != 0) ? pend_up   : btn_up_s;
   assign down_req = (EDGE_MODE != 0) ? pend_down : btn_down_s;

   always_comb begin
      count_d = count;
      wrap_d  = 1'b0;
      if (load) begin
         // Load overrides any coincident step; out-of-range values clamp.
         count_d = (load_val > MAXV) ? MAXV : load_val;
      end else if (tick_fire) begin
         if (up_req && !down_req) begin
            if (count == MAXV) begin
               if (SATURATE != 0) begin
                  count_d = MAXV;
               end else begin
                  count_d = '0;
                  wrap_d  = 1'b1;
               end
            end else begin
               // count < MAXV here, so the increment cannot overflow WIDTH.
               count_d = count + 1'b1;
            end
         end else if (down_req && !up_req) begin
            if (count == '0) begin
               if (SATURATE != 0) begin
                  count_d = '0;
               end else begin
                  count_d = MAXV;
                  wrap_d  = 1'b1;
               end
            end else begin
               count_d = count - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
         tick  <= 1'b0;
         wrap  <= 1'b0;
      end else begin
         count <= count_d;
         tick  <= tick_fire;
         wrap  <= wrap_d;
      end
   end

   assign at_max = (count == MAXV);
   assign at_min = (count == '0);

endmodule

// File: doc/updown_tick_counter.md
Name: updown_tick_counter

Overview:
Parametrised up/down counter for board LED and user-button logic. A free-running prescaler generates a periodic step tick; on each tick the count steps up or down according to two push-button inputs. Generalised over count width, tick period, terminal value, wrap/saturate policy and level/edge step mode. Adds a synchronous load, input synchronisers and boundary flags. Sits between the raw board buttons and LED/display outputs.

Parameters:
WIDTH, 4, count width in bits (1..16)
TICK_DIV, 125000000, clk cycles per step tick (>=1); prescaler width = max(1, $clog2(TICK_DIV))
MAX_VAL, 2**WIDTH-1, terminal count (1..2**WIDTH-1); count range is 0..MAX_VAL
SATURATE, 0, 0 = wrap at the ends, 1 = clamp at the ends
EDGE_MODE, 0, 0 = level (one step per tick while held), 1 = edge (one step per press)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (asserted when 0)
btn_up  in  1  raw async button, count up
btn_down  in  1  raw async button, count down
en  in  1  prescaler enable
load  in  1  synchronous load strobe
load_val  in  WIDTH  value to load
count  out  WIDTH  current count, registered
tick  out  1  one-cycle step strobe, registered
wrap  out  1  one-cycle pulse when the count wraps, registered
at_max  out  1  count == MAX_VAL, combinational from count
at_min  out  1  count == 0, combinational from count

Behaviour:
- Reset (rst=0, async): count=0, prescaler=0, synchroniser flops=0, pending requests=0, tick=0, wrap=0. Hence at_min=1 and at_max=0. Release is synchronous to clk; the first prescaler increment occurs on the first clk edge after release.
- Synchronisers: each button passes through 2 flops. Internal btn_*_s lags the pin by 2 cycles.
- Prescaler: counts 0..TICK_DIV-1 while en=1, then returns to 0. tick=1 for exactly the cycle after the prescaler holds TICK_DIV-1 and en=1, so the period is exactly TICK_DIV cycles. TICK_DIV=1 gives tick=1 every cycle while en=1.
- en=0: the prescaler freezes (holds its value, no reset) and no tick is generated. In edge mode, presses are still captured as pending.
- Step decision, evaluated on the cycle the tick condition fires and registered with tick:
  - Level mode: uses btn_up_s and btn_down_s at that edge.
  - Edge mode: uses pend_up and pend_down. Each is set by a rising edge of the corresponding synchronised button, at most one per press. Both are cleared on the tick that consumes them. A new rising edge arriving in the same cycle as a clearing tick stays pending.
  - up only: count+1. down only: count-1. Both or neither: no change (both pending flags are cleared in edge mode).
- Boundaries:
  - Up at MAX_VAL: SATURATE=0 gives count=0 and wrap=1 for one cycle; SATURATE=1 holds MAX_VAL with wrap=0.
  - Down at 0: SATURATE=0 gives count=MAX_VAL and wrap=1; SATURATE=1 holds 0.
  - Arithmetic never exceeds MAX_VAL; no intermediate overflow beyond WIDTH.
- Load: highest priority, applied on the next clk edge regardless of tick or en. count=min(load_val, MAX_VAL). Load also clears both pending flags. If load coincides with a tick, the load wins, tick still pulses, and wrap=0. The prescaler is unaffected.
- Outputs are glitch-free registered, except at_max and at_min.

Test Plan:
1. Reset and tick period, TICK_DIV=4, en=1: hold rst=0 then release. Required: count=0, at_min=1; tick pulses every 4 cycles, first pulse 4 cycles after release.
2. Level up with wrap, WIDTH=4, SATURATE=0: hold btn_up for 17 ticks. Required: count 1..15, then 0 with wrap=1 on that tick only, then 1.
3. Saturate down, SATURATE=1, count=0: hold btn_down for 3 ticks. Required: count stays 0, wrap never asserts, at_min=1 throughout.
4. Edge mode, TICK_DIV=8: 3 short presses of btn_up (2 cycles each) within one tick window, then hold btn_up for 5 ticks. Required: +1 for the 3-press window, +1 total for the hold; both buttons pressed together gives no change.
5. Load and priority, MAX_VAL=9: load=1 with load_val=12 coincident with a tick while btn_up is held. Required: count=9, at_max=1, wrap=0, and the next up tick with SATURATE=0 gives count=0 with wrap=1.
6. en gating and async reset: drop en for 10 cycles mid-period, then drive rst=0 between clock edges mid-count. Required: no tick while en=0 and the period resumes from the frozen value; count drops to 0 immediately on rst=0 without waiting for a clock edge.
